// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the M-stage load/store unit and the data memory.
// The unit drives a request and holds it until gnt; load data comes back later with rvalid.
interface mem_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: checks the access, runs one req/gnt/rvalid bus transaction,
// aligns/extends load data and stalls the pipeline until the access retires in DONE.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     MemReadM,
    input  logic                     MemWriteM,
    input  logic [31:0]              ALUResultM,
    input  logic [31:0]              WriteDataM,
    input  logic [2:0]               funct3M,
    mem_access_unit_if.master        dmem,
    output logic [31:0]              ReadDataM,
    output logic                     StallM,
    output logic                     FaultM,
    output logic [1:0]               FaultCauseM
);

    // Counter only has to reach TIMEOUT_CYCLES-1, which always fits in clog2(TIMEOUT_CYCLES) bits.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t        state, nxt;
    logic          memOp, illegal, misal, toHit;
    logic [1:0]    off;
    logic [3:0]    beN;
    logic [31:0]   wdN;
    logic [CW-1:0] cnt;

    logic          weQ, faultQ;
    logic [31:0]   addrQ, wdQ;
    logic [3:0]    beQ;
    logic [1:0]    offQ, causeQ;
    logic [2:0]    f3Q;
    logic [31:0]   shifted, loadVal;

    assign memOp = MemReadM | MemWriteM;
    assign off   = ALUResultM[1:0];
    assign toHit = (TIMEOUT_CYCLES != 0) && (cnt == LAST);

    always_comb begin
        illegal = 1'b0;
        if (MemReadM && MemWriteM)
            illegal = 1'b1;
        else if (MemReadM)
            illegal = !(funct3M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        else if (MemWriteM)
            illegal = !(funct3M inside {3'b000, 3'b001, 3'b010});
    end

    assign misal = ((funct3M[1:0] == 2'b01) && off[0]) ||
                   ((funct3M[1:0] == 2'b10) && (off != 2'b00));

    always_comb begin
        beN = 4'b1111;
        wdN = WriteDataM;
        case (funct3M[1:0])
            2'b00: begin
                beN = 4'b0001 << off;
                wdN = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                beN = 4'b0011 << off;
                wdN = {2{WriteDataM[15:0]}};
            end
            default: ;
        endcase
    end

    assign shifted = dmem.dmem_rdata >> {offQ, 3'b000};

    always_comb begin
        loadVal = shifted;
        case (f3Q)
            3'b000:  loadVal = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  loadVal = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  loadVal = {24'b0, shifted[7:0]};
            3'b101:  loadVal = {16'b0, shifted[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // gnt/rvalid win over the timeout when they arrive on the last allowed cycle.
    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (memOp) nxt = (illegal || misal) ? DONE : REQ;
            REQ: begin
                if (dmem.dmem_gnt) nxt = weQ ? DONE : RESP;
                else if (toHit)    nxt = DONE;
            end
            RESP: if (dmem.dmem_rvalid || toHit) nxt = DONE;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            weQ       <= 1'b0;
            addrQ     <= '0;
            wdQ       <= '0;
            beQ       <= '0;
            offQ      <= '0;
            f3Q       <= '0;
            faultQ    <= 1'b0;
            causeQ    <= '0;
            ReadDataM <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (memOp) begin
                        if (illegal || misal) begin
                            faultQ    <= 1'b1;
                            causeQ    <= illegal ? 2'b10 : 2'b01;
                            ReadDataM <= '0;
                        end else begin
                            faultQ <= 1'b0;
                            addrQ  <= {ALUResultM[31:2], 2'b00};
                            weQ    <= MemWriteM;
                            beQ    <= beN;
                            wdQ    <= wdN;
                            offQ   <= off;
                            f3Q    <= funct3M;
                        end
                    end
                end
                REQ, RESP: begin
                    cnt <= cnt + 1'b1;
                    if (state == RESP && dmem.dmem_rvalid) begin
                        ReadDataM <= loadVal;
                    end else if (toHit && !(state == REQ && dmem.dmem_gnt)) begin
                        faultQ    <= 1'b1;
                        causeQ    <= 2'b11;
                        ReadDataM <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Request is decoded from the async-reset state so it drops the moment rst rises.
    assign dmem.dmem_req   = (state == REQ);
    assign dmem.dmem_we    = weQ;
    assign dmem.dmem_addr  = addrQ;
    assign dmem.dmem_be    = beQ;
    assign dmem.dmem_wdata = wdQ;

    assign StallM      = !rst && memOp && (state != DONE);
    assign FaultM      = (state == DONE) && faultQ;
    assign FaultCauseM = FaultM ? causeQ : 2'b00;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: unit 0 uses the default timeout, unit 1 a 4-cycle timeout.
module tb_mem_access_unit;

    typedef struct {
        logic [31:0] rd;
        logic        fault;
        logic [1:0]  cause;
        int          stall;
        int          reqs;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] addr;
        logic        we;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        rdIn[2], wrIn[2], gntIn[2], rvIn[2];
    logic [31:0] addrIn[2], wdIn[2], rdataIn[2];
    logic [2:0]  f3In[2];
    logic [31:0] rdOut[2], baddr[2], bwd[2];
    logic        stallOut[2], faultOut[2], reqOut[2], weOut[2];
    logic [1:0]  causeOut[2];
    logic [3:0]  bbe[2];

    mem_access_unit_if bus0();
    mem_access_unit_if bus1();

    assign bus0.dmem_gnt = gntIn[0];  assign bus0.dmem_rvalid = rvIn[0];  assign bus0.dmem_rdata = rdataIn[0];
    assign bus1.dmem_gnt = gntIn[1];  assign bus1.dmem_rvalid = rvIn[1];  assign bus1.dmem_rdata = rdataIn[1];
    assign reqOut[0] = bus0.dmem_req; assign weOut[0] = bus0.dmem_we; assign baddr[0] = bus0.dmem_addr;
    assign bbe[0]    = bus0.dmem_be;  assign bwd[0]   = bus0.dmem_wdata;
    assign reqOut[1] = bus1.dmem_req; assign weOut[1] = bus1.dmem_we; assign baddr[1] = bus1.dmem_addr;
    assign bbe[1]    = bus1.dmem_be;  assign bwd[1]   = bus1.dmem_wdata;

    mem_access_unit #(.TIMEOUT_CYCLES(255)) dut0 (
        .clk(clk), .rst(rst), .MemReadM(rdIn[0]), .MemWriteM(wrIn[0]),
        .ALUResultM(addrIn[0]), .WriteDataM(wdIn[0]), .funct3M(f3In[0]), .dmem(bus0),
        .ReadDataM(rdOut[0]), .StallM(stallOut[0]), .FaultM(faultOut[0]), .FaultCauseM(causeOut[0])
    );

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut1 (
        .clk(clk), .rst(rst), .MemReadM(rdIn[1]), .MemWriteM(wrIn[1]),
        .ALUResultM(addrIn[1]), .WriteDataM(wdIn[1]), .funct3M(f3In[1]), .dmem(bus1),
        .ReadDataM(rdOut[1]), .StallM(stallOut[1]), .FaultM(faultOut[1]), .FaultCauseM(causeOut[1])
    );

    int nCmp = 0;
    int nBad = 0;
    exp_t sb[$];
    logic [31:0] prevRd[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Byte-lane view of the access: lanes o..o+size-1 active, store bytes repeat every size bytes.
    function automatic exp_t model(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] rdata, input logic [31:0] prev);
        exp_t e;
        int o, size;
        logic ill, mis;
        logic [7:0]  b;
        logic [15:0] h;
        o    = int'(a[1:0]);
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        ill  = (rd && wr) || (rd && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) || (wr && f3 > 3'd2);
        mis  = !ill && ((size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00));
        e.addr  = {a[31:2], 2'b00};
        e.we    = wr;
        e.fault = ill || mis;
        e.cause = ill ? 2'd2 : (mis ? 2'd1 : 2'd0);
        e.stall = 0;
        e.reqs  = 0;
        for (int i = 0; i < 4; i++) begin
            e.be[i]        = (i >= o) && (i < o + size);
            e.wd[8*i +: 8] = wd[8*(i % size) +: 8];
        end
        if (e.fault) e.rd = 32'h0;
        else if (!rd) e.rd = prev;
        else begin
            b = rdata[8*o +: 8];
            h = (o == 2) ? rdata[31:16] : rdata[15:0];
            case (f3)
                3'b000:  e.rd = {{24{b[7]}}, b};
                3'b100:  e.rd = {24'h0, b};
                3'b001:  e.rd = {{16{h[15]}}, h};
                3'b101:  e.rd = {16'h0, h};
                default: e.rd = rdata;
            endcase
        end
        return e;
    endfunction

    // gDly/rDly: idle cycles before gnt/rvalid, -1 = never. tmo: the unit's timeout.
    task automatic runOp(input int u, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                         input int gDly, input int rDly, input int tmo, input logic lateRv);
        exp_t e, g;
        int gNeed, rNeed, busy, stallN, reqN, respN;
        logic granted, busBad, done;
        e = model(rd, wr, f3, addr, wd, rdata, prevRd[u]);
        if (e.fault) begin
            e.stall = 1;
        end else begin
            gNeed = (gDly < 0) ? 100000 : gDly + 1;
            rNeed = wr ? 0 : ((rDly < 0) ? 100000 : rDly + 1);
            busy  = gNeed + rNeed;
            if (tmo != 0 && busy > tmo) begin
                e.fault = 1'b1; e.cause = 2'd3; e.rd = 32'h0;
                e.stall = 1 + tmo;
                e.reqs  = (gNeed > tmo) ? tmo : gNeed;
            end else begin
                e.stall = 1 + busy;
                e.reqs  = gNeed;
            end
        end
        sb.push_back(e);

        rdIn[u] = rd; wrIn[u] = wr; f3In[u] = f3; addrIn[u] = addr; wdIn[u] = wd;
        rdataIn[u] = rdata; gntIn[u] = 1'b0; rvIn[u] = 1'b0;
        stallN = 0; reqN = 0; respN = 0; granted = 1'b0; busBad = 1'b0; done = 1'b0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            #1;
            if (!stallOut[u]) begin
                done = 1'b1;
                g = sb.pop_front();
                chk("ReadDataM", rdOut[u], g.rd);
                chk("FaultM", 32'(faultOut[u]), 32'(g.fault));
                chk("FaultCauseM", 32'(causeOut[u]), 32'(g.cause));
                chk("stallCycles", 32'(stallN), 32'(g.stall));
                chk("reqCycles", 32'(reqN), 32'(g.reqs));
                chk("busStable", 32'(busBad), 32'd0);
                prevRd[u] = g.rd;
                rdIn[u] = 1'b0; wrIn[u] = 1'b0; gntIn[u] = 1'b0; rvIn[u] = lateRv;
                if (lateRv) rdataIn[u] = 32'h1234_5678;
                @(negedge clk); #1;
                chk("faultPulse", 32'(faultOut[u]), 32'd0);
                chk("rdHold", rdOut[u], g.rd);
                rvIn[u] = 1'b0;
            end else begin
                stallN++;
                gntIn[u] = 1'b0; rvIn[u] = 1'b0;
                if (reqOut[u]) begin
                    if (baddr[u] !== e.addr || bbe[u] !== e.be || weOut[u] !== e.we ||
                        (e.we && bwd[u] !== e.wd)) busBad = 1'b1;
                    if (gDly >= 0 && reqN == gDly) begin
                        gntIn[u] = 1'b1;
                        granted  = !wr;
                    end
                    reqN++;
                end else if (granted) begin
                    if (rDly >= 0 && respN == rDly) rvIn[u] = 1'b1;
                    respN++;
                end
                @(negedge clk);
            end
        end
        if (!done) begin
            chk("opCompleted", 32'(done), 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            rdIn[u] = 1'b0; wrIn[u] = 1'b0; gntIn[u] = 1'b0; rvIn[u] = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        int kind;
        logic [2:0] f3;
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            rdIn[u] = 0; wrIn[u] = 0; gntIn[u] = 0; rvIn[u] = 0;
            addrIn[u] = 0; wdIn[u] = 0; rdataIn[u] = 0; f3In[u] = 0; prevRd[u] = 0;
        end
        repeat (2) @(negedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("rstReq", 32'(reqOut[u]), 32'd0);
            chk("rstStall", 32'(stallOut[u]), 32'd0);
            chk("rstRd", rdOut[u], 32'd0);
            chk("rstFault", 32'(faultOut[u]), 32'd0);
            chk("rstCause", 32'(causeOut[u]), 32'd0);
            chk("rstBe", 32'(bbe[u]), 32'd0);
            chk("rstAddr", baddr[u], 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        runOp(0, 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, 255, 0);
        runOp(0, 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_0011, 0, 0, 255, 0);
        runOp(0, 1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_0011, 1, 2, 255, 0);
        runOp(0, 0, 1, 3'b001, 32'h102, 32'h0000_ABCD, 32'h0, 5, 0, 255, 0);
        runOp(0, 1, 0, 3'b010, 32'h101, 32'h0, 32'h5555_5555, 0, 0, 255, 0);
        runOp(0, 1, 0, 3'b011, 32'h100, 32'h0, 32'h5555_5555, 0, 0, 255, 0);
        runOp(0, 1, 1, 3'b010, 32'h100, 32'h0, 32'h5555_5555, 0, 0, 255, 0);
        runOp(0, 0, 1, 3'b100, 32'h100, 32'h1, 32'h0, 0, 0, 255, 0);
        runOp(0, 0, 1, 3'b001, 32'h103, 32'h1, 32'h0, 0, 0, 255, 0);
        runOp(0, 1, 0, 3'b001, 32'h102, 32'h0, 32'h8001_7F00, 0, 1, 255, 0);
        runOp(0, 1, 0, 3'b101, 32'h102, 32'h0, 32'h8001_7F00, 2, 0, 255, 0);
        runOp(0, 0, 1, 3'b000, 32'h101, 32'hFFFF_FF5A, 32'h0, 0, 0, 255, 0);
        runOp(0, 0, 1, 3'b010, 32'h104, 32'h1234_5678, 32'h0, 1, 0, 255, 0);

        runOp(1, 1, 0, 3'b010, 32'h300, 32'h0, 32'h1111_2222, -1, 0, 4, 1);
        runOp(1, 1, 0, 3'b010, 32'h304, 32'h0, 32'h3333_4444, 0, -1, 4, 1);
        runOp(1, 1, 0, 3'b010, 32'h308, 32'h0, 32'h5555_6666, 2, 0, 4, 0);
        runOp(1, 0, 1, 3'b010, 32'h30C, 32'h7777_8888, 32'h0, 3, 0, 4, 0);

        for (int n = 0; n < 16; n++) begin
            kind = $urandom_range(0, 5);
            f3   = 3'($urandom_range(0, 7));
            runOp(0, kind != 1, kind == 1 || kind == 5, f3, $urandom, $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), 255, 0);
        end

        // Reset while a load waits in RESP: request and stall drop at once, late data is dropped.
        rdIn[0] = 1'b1; wrIn[0] = 1'b0; f3In[0] = 3'b010; addrIn[0] = 32'h200;
        rdataIn[0] = 32'hCAFE_F00D; gntIn[0] = 1'b0; rvIn[0] = 1'b0;
        @(negedge clk);
        gntIn[0] = 1'b1;
        @(negedge clk);
        gntIn[0] = 1'b0;
        #1;
        chk("preRstStall", 32'(stallOut[0]), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstMidReq", 32'(reqOut[0]), 32'd0);
        chk("rstMidStall", 32'(stallOut[0]), 32'd0);
        chk("rstMidRd", rdOut[0], 32'd0);
        rdIn[0] = 1'b0;
        rvIn[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rvIn[0] = 1'b0;
        #1;
        chk("rstLateRv", rdOut[0], 32'd0);
        chk("rstIdleReq", 32'(reqOut[0]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
